seg7_scan_ctrl: RTL

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. One shared `bcd_to_7seg` decoder serves all digits: the block holds a frame of BCD digits, steps a digit index at a fixed refresh rate, and drives the decoder input, the anode enables and the decimal point. It sits between the register/datapath logic that produces BCD values and the display pins. New values are applied only on frame boundaries, so the display never shows a mix of two frames.

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/bcd_to_7seg.sv | 28 ++
 rtl/seg7_scan_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller and its decoder.
package seg7_pkg;

    // Widest display the controller supports.
    localparam int MAX_DIGITS = 8;

    // Segment pattern with every segment off.
    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

    // One BCD digit.
    typedef logic [3:0] bcd_t;

    // All anodes off (active-low); slice to the display width in use.
    localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

    // A BCD digit is only meaningful for values 0..9.
    function automatic logic bcd_valid(input bcd_t v);
        return (v <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD to 7-segment decoder, active-high segments ordered {g,f,e,d,c,b,a}.
// Values above 9 decode to all segments off.
module bcd_to_7seg
    import seg7_pkg::*;
(
    input  bcd_t       bcd,
    output logic [6:0] seg
);

    // Combinational lookup of the segment pattern for one digit.
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment
// display. One shared decoder is fed the digit selected by the scan index;
// new frames are swapped in only when the index wraps, so a frame is never
// shown half old and half new.
// Optional feature: define SEG7_LZ_BLANK_EN for leading-zero suppression.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;

    localparam logic [PW-1:0] PCNT_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] PCNT_BLANK = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]         pcnt_q, pcnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         act_dig_q, act_dig_d;
    logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
    logic [DW-1:0]         pend_dig_q, pend_dig_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pending_q, pending_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_done_q, frame_done_d;

    logic                  slot_end;
    logic                  wrap;
    bcd_t                  cur_bcd;
    logic                  cur_dp;
    logic                  cur_lz;
    logic [6:0]            dec_seg;

    // Prescaler and digit index: the index steps once per slot and wraps per frame.
    always_comb begin
        slot_end = (pcnt_q == PCNT_LAST);
        wrap     = slot_end && (idx_q == IDX_LAST);
        pcnt_d   = slot_end ? '0 : pcnt_q + 1'b1;
        idx_d    = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Frame buffering: loads park in the pending frame, the active frame changes only on wrap.
    always_comb begin
        act_dig_d  = act_dig_q;
        act_dp_d   = act_dp_q;
        pend_dig_d = pend_dig_q;
        pend_dp_d  = pend_dp_q;
        pending_d  = pending_q;
        if (wrap) begin
            // A load coinciding with the wrap bypasses the pending buffer.
            if (load) begin
                act_dig_d = digits_in;
                act_dp_d  = dp_in;
            end else if (pending_q) begin
                act_dig_d = pend_dig_q;
                act_dp_d  = pend_dp_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            pend_dig_d = digits_in;
            pend_dp_d  = dp_in;
            pending_d  = 1'b1;
        end
    end

    // Digit selection, leading-zero mask and next values of the registered pins.
    always_comb begin
        cur_bcd = '0;
        cur_dp  = 1'b0;
        cur_lz  = 1'b0;
        an_d    = AN_OFF[NUM_DIGITS-1:0];
`ifdef SEG7_LZ_BLANK_EN
        begin
            // A digit is a leading zero when it and every digit above it are zero.
            logic zero_run;
            zero_run = 1'b1;
            for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
                zero_run = zero_run && (act_dig_q[4*k +: 4] == 4'd0);
                if (idx_q == IW'(k)) begin
                    cur_lz = zero_run;
                end
            end
        end
`else
        cur_lz = 1'b0;
`endif
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_bcd = act_dig_q[4*k +: 4];
                cur_dp  = act_dp_q[k];
                // The anode stays off for the first BLANK_CYCLES of each slot.
                if (pcnt_q >= PCNT_BLANK) begin
                    an_d[k] = 1'b0;
                end
            end
        end
        seg_d        = (!bcd_valid(cur_bcd) || cur_lz) ? SEG_BLANK : dec_seg;
        dp_d         = cur_dp;
        frame_done_d = wrap;
    end

    bcd_to_7seg u_dec (
        .bcd (cur_bcd),
        .seg (dec_seg)
    );

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q       <= '0;
            idx_q        <= '0;
            act_dig_q    <= '0;
            act_dp_q     <= '0;
            pend_dig_q   <= '0;
            pend_dp_q    <= '0;
            pending_q    <= 1'b0;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b0;
            an_q         <= AN_OFF[NUM_DIGITS-1:0];
            frame_done_q <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            idx_q        <= idx_d;
            act_dig_q    <= act_dig_d;
            act_dp_q     <= act_dp_d;
            pend_dig_q   <= pend_dig_d;
            pend_dp_q    <= pend_dp_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule
